alarm_clock_core: RTL and testbench

- Parametrised successor to the team's single-alarm seven-segment clock.
- Fully synchronous timekeeper: hh:mm:ss in 24-h BCD, N independent alarms, ring timeout and snooze, 12/24-h display select.
- Edit-field blinking, six seven-segment digit outputs.
- Sits between the board's button-debounce/pulse block (user inputs) and the LED/buzzer pins.

---
 rtl/clock_pkg.sv | 58 +++++
 rtl/alarm_clock_core_seg7_dec.sv | 37 +++
 rtl/alarm_clock_core.sv | 245 ++++++++++++++++++++++++
 tb/tb_alarm_clock_core.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types, segment constants and small time helpers for the alarm clock.
package clock_pkg;

  // Edit field within the selected target.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MIN  = 2'd1,
    HOUR = 2'd2
  } field_e;

  // Target index: 0 is the running time, k+1 is alarm k.
  localparam logic [3:0] TGT_TIME = 4'd0;

  // Active-low segment patterns {a..g}, a = MSB.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Hour kept binary 0..23 so both display digits always change together.
  typedef struct packed {
    logic [4:0] h;
    logic [2:0] m1;
    logic [3:0] m2;
    logic [2:0] s1;
    logic [3:0] s2;
  } bcd_time_t;

  function automatic logic [4:0] hour_to_12h(input logic [4:0] h);
    if (h == 5'd0)      return 5'd12;
    else if (h > 5'd12) return h - 5'd12;
    else                return h;
  endfunction

  function automatic logic [4:0] hour_inc(input logic [4:0] h);
    return (h == 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  // Minutes +1 in BCD, 59 wraps to 00; result is {m1, m2}.
  function automatic logic [6:0] min_inc(input logic [2:0] m1, input logic [3:0] m2);
    if (m2 != 4'd9)      return {m1, m2 + 4'd1};
    else if (m1 != 3'd5) return {m1 + 3'd1, 4'd0};
    else                 return 7'd0;
  endfunction

  // BCD minutes to binary 0..59.
  function automatic logic [5:0] min_bin(input logic [2:0] m1, input logic [3:0] m2);
    return {m1, 3'b000} + {2'b00, m1, 1'b0} + {2'b00, m2};
  endfunction

endpackage

// File: rtl/alarm_clock_core_seg7_dec.sv
// One BCD digit (with blanking) to seven segments of selectable polarity.
module seg7_dec
  import clock_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] seg_low;

  // Active-low pattern lookup; codes above 9 show blank.
  always_comb begin
    // NOTE: default before the case so every path assigns and no latch is inferred.
    seg_low = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg_low = SEG_0;
        4'd1:    seg_low = SEG_1;
        4'd2:    seg_low = SEG_2;
        4'd3:    seg_low = SEG_3;
        4'd4:    seg_low = SEG_4;
        4'd5:    seg_low = SEG_5;
        4'd6:    seg_low = SEG_6;
        4'd7:    seg_low = SEG_7;
        4'd8:    seg_low = SEG_8;
        4'd9:    seg_low = SEG_9;
        default: seg_low = SEG_BLANK;
      endcase
    end
  end

  assign seg = SEG_ACTIVE_LOW ? seg_low : ~seg_low;

endmodule

// File: rtl/alarm_clock_core.sv
// 24-h BCD timekeeper with N alarms, ring timeout, snooze and 12/24-h display.
module alarm_clock_core
  import clock_pkg::*;
#(
  parameter int CLK_HZ     = 10,
  parameter int N_ALARMS   = 2,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  localparam int IDX_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1,
  localparam int PW    = $clog2(CLK_HZ)
) (
  input  logic                Cp,
  input  logic                reset,
  input  logic                MODE,
  input  logic                CMODE,
  input  logic                Ch,
  input  logic                APM,
  input  logic [N_ALARMS-1:0] ALM,
  input  logic                SNZ,
  output logic [6:0]          H1,
  output logic [6:0]          H2,
  output logic [6:0]          M1,
  output logic [6:0]          M2,
  output logic [6:0]          S1,
  output logic [6:0]          S2,
  output logic                PM,
  output logic                SND,
  output logic [IDX_W-1:0]    ALM_IDX
);

  logic [PW-1:0] presc;
  logic [3:0]    tgt, tgt_nx;
  field_e        field, field_nx;
  bcd_time_t     tm, tm_nx, sel;
  logic [4:0]    alm_h  [N_ALARMS];
  logic [2:0]    alm_m1 [N_ALARMS];
  logic [3:0]    alm_m2 [N_ALARMS];
  logic [7:0]    ring_cnt;
  logic          snz_act;
  logic [4:0]    snz_h, dl_h, disp_h;
  logic [5:0]    snz_m, dl_m;
  logic [6:0]    snz_sum;
  logic          tick, adv, new_minute, hit, snz_hit, blink;
  logic          clear_secs, inc_min, inc_hour;
  logic [IDX_W-1:0] hit_idx;
  logic [1:0]    h_tens;
  logic [3:0]    h_ones;

  assign tick       = (presc == PW'(CLK_HZ - 1));
  assign adv        = tick && ((tgt != TGT_TIME) || (field == RUN));
  assign new_minute = adv && (tm_nx.s1 == 3'd0) && (tm_nx.s2 == 4'd0);
  assign blink      = (presc < PW'(CLK_HZ / 2));

  // Target/field state register.
  always_ff @(posedge Cp or posedge reset) begin
    if (reset) begin
      tgt   <= TGT_TIME;
      field <= RUN;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
      tgt   <= tgt_nx;
      field <= field_nx;
    end
  end

  // Next target/field: MODE steps the target and wins over CMODE.
  always_comb begin
    tgt_nx   = tgt;
    field_nx = field;
    if (MODE) begin
      tgt_nx   = (tgt == 4'(N_ALARMS)) ? TGT_TIME : tgt + 4'd1;
      field_nx = RUN;
    end else if (CMODE) begin
      case (field)
        RUN:     field_nx = MIN;
        MIN:     field_nx = HOUR;
        default: field_nx = RUN;
      endcase
    end
  end

  // Edit strobes decoded from the current target/field.
  always_comb begin
    clear_secs = CMODE && !MODE && (field == RUN) && (tgt == TGT_TIME);
    inc_min    = Ch && (field == MIN);
    inc_hour   = Ch && (field == HOUR);
  end

  // Prescaler: free-running, restarted when the time's minute field is entered.
  always_ff @(posedge Cp or posedge reset) begin
    if (reset)            presc <= '0;
    else if (clear_secs)  presc <= '0;
    else if (tick)        presc <= '0;
    else                  presc <= presc + PW'(1);
  end

  // Time one second ahead, BCD carries up to the 23:59:59 wrap.
  always_comb begin
    tm_nx = tm;
    if (tm.s2 != 4'd9) begin
      tm_nx.s2 = tm.s2 + 4'd1;
    end else begin
      tm_nx.s2 = 4'd0;
      if (tm.s1 != 3'd5) begin
        tm_nx.s1 = tm.s1 + 3'd1;
      end else begin
        tm_nx.s1 = 3'd0;
        {tm_nx.m1, tm_nx.m2} = min_inc(tm.m1, tm.m2);
        if ((tm.m1 == 3'd5) && (tm.m2 == 4'd9)) tm_nx.h = hour_inc(tm.h);
      end
    end
  end

  // Timekeeping and direct edits of the time (edits only happen while frozen).
  always_ff @(posedge Cp or posedge reset) begin
    if (reset) begin
      tm <= '0;
    end else if (clear_secs) begin
      tm.s1 <= 3'd0;
      tm.s2 <= 4'd0;
    end else if (adv) begin
      tm <= tm_nx;
    end else if (tgt == TGT_TIME) begin
      if (inc_min)  {tm.m1, tm.m2} <= min_inc(tm.m1, tm.m2);
      if (inc_hour) tm.h <= hour_inc(tm.h);
    end
  end

  // Alarm registers edited while their target is selected.
  always_ff @(posedge Cp or posedge reset) begin
    if (reset) begin
      // NOTE: only N_ALARMS small registers, so they are reset like ordinary flops.
      for (int k = 0; k < N_ALARMS; k++) begin
        alm_h[k]  <= '0;
        alm_m1[k] <= '0;
        alm_m2[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_ALARMS; k++) begin
        if (tgt == 4'(k + 1)) begin
          if (inc_min)  {alm_m1[k], alm_m2[k]} <= min_inc(alm_m1[k], alm_m2[k]);
          if (inc_hour) alm_h[k] <= hour_inc(alm_h[k]);
        end
      end
    end
  end

  // Alarm match against the upcoming hh:mm; lowest enabled index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = N_ALARMS - 1; k >= 0; k--) begin
      if (ALM[k] && (tm_nx.h == alm_h[k]) && (tm_nx.m1 == alm_m1[k]) && (tm_nx.m2 == alm_m2[k])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(k);
      end
    end
    snz_hit = snz_act && (tm_nx.h == snz_h) && (min_bin(tm_nx.m1, tm_nx.m2) == snz_m);
  end

  // Snooze deadline: current hh:mm plus SNOOZE_MIN, wrapping past midnight.
  always_comb begin
    snz_sum = {1'b0, min_bin(tm.m1, tm.m2)} + 7'(SNOOZE_MIN);
    if (snz_sum >= 7'd60) begin
      dl_m = 6'(snz_sum - 7'd60);
      dl_h = hour_inc(tm.h);
    end else begin
      dl_m = snz_sum[5:0];
      dl_h = tm.h;
    end
  end

  // Ring control: disable, snooze, timeout, then new ring (snooze re-ring first).
  always_ff @(posedge Cp or posedge reset) begin
    if (reset) begin
      SND      <= 1'b0;
      ALM_IDX  <= '0;
      ring_cnt <= '0;
      snz_act  <= 1'b0;
      snz_h    <= '0;
      snz_m    <= '0;
    end else if (SND && !ALM[ALM_IDX]) begin
      SND     <= 1'b0;
      snz_act <= 1'b0;
    end else if (SND && SNZ) begin
      SND     <= 1'b0;
      snz_act <= 1'b1;
      snz_h   <= dl_h;
      snz_m   <= dl_m;
    end else if (SND && tick) begin
      ring_cnt <= ring_cnt - 8'd1;
      if (ring_cnt <= 8'd1) SND <= 1'b0;
    end else if (!SND && new_minute) begin
      if (snz_hit) begin
        SND      <= 1'b1;
        ring_cnt <= 8'(RING_SECS);
        snz_act  <= 1'b0;
      end else if (hit) begin
        SND      <= 1'b1;
        ALM_IDX  <= hit_idx;
        ring_cnt <= 8'(RING_SECS);
      end
    end
  end

  // Displayed value: running time or the selected alarm with seconds forced to 00.
  always_comb begin
    sel = tm;
    for (int k = 0; k < N_ALARMS; k++) begin
      if (tgt == 4'(k + 1)) begin
        sel.h  = alm_h[k];
        sel.m1 = alm_m1[k];
        sel.m2 = alm_m2[k];
        sel.s1 = 3'd0;
        sel.s2 = 4'd0;
      end
    end
  end

  // Hour digits after the optional 12-h mapping.
  always_comb begin
    disp_h = APM ? hour_to_12h(sel.h) : sel.h;
    if (disp_h >= 5'd20) begin
      h_tens = 2'd2;
      h_ones = 4'(disp_h - 5'd20);
    end else if (disp_h >= 5'd10) begin
      h_tens = 2'd1;
      h_ones = 4'(disp_h - 5'd10);
    end else begin
      h_tens = 2'd0;
      h_ones = disp_h[3:0];
    end
  end

  assign PM = (sel.h >= 5'd12);

  seg7_dec #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_h1 (.bcd({2'b00, h_tens}), .blank((field == HOUR) && blink), .seg(H1));
  seg7_dec #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_h2 (.bcd(h_ones),          .blank((field == HOUR) && blink), .seg(H2));
  seg7_dec #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_m1 (.bcd({1'b0, sel.m1}),  .blank((field == MIN) && blink),  .seg(M1));
  seg7_dec #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_m2 (.bcd(sel.m2),          .blank((field == MIN) && blink),  .seg(M2));
  seg7_dec #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_s1 (.bcd({1'b0, sel.s1}),  .blank(1'b0),                     .seg(S1));
  seg7_dec #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_s2 (.bcd(sel.s2),          .blank(1'b0),                     .seg(S2));

endmodule

// File: tb/tb_alarm_clock_core.sv
// Directed bench for alarm_clock_core with CLK_HZ=2, two alarms, 3 s ring, 5 min snooze.
module tb_alarm_clock_core;

  localparam int CLK_HZ = 2;
  localparam logic [6:0] BL = 7'b1111111;

  logic       Cp = 1'b0;
  logic       reset, MODE, CMODE, Ch, APM, SNZ;
  logic [1:0] ALM;
  logic [6:0] H1, H2, M1, M2, S1, S2;
  logic       PM, SND;
  logic [0:0] ALM_IDX;
  logic [41:0] segs;

  int n_vec = 0;
  int n_err = 0;
  int presc_m = 0;
  logic [41:0] e;

  assign segs = {H1, H2, M1, M2, S1, S2};

  alarm_clock_core #(
    .CLK_HZ(CLK_HZ), .N_ALARMS(2), .RING_SECS(3), .SNOOZE_MIN(5), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .Cp(Cp), .reset(reset), .MODE(MODE), .CMODE(CMODE), .Ch(Ch), .APM(APM), .ALM(ALM), .SNZ(SNZ),
    .H1(H1), .H2(H2), .M1(M1), .M2(M2), .S1(S1), .S2(S2), .PM(PM), .SND(SND), .ALM_IDX(ALM_IDX)
  );

  always #5 Cp = ~Cp;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      9: return 7'b0001100;  default: return BL;
    endcase
  endfunction

  function automatic logic [41:0] disp(input int h, input int m, input int s, input bit bh, input bit bm);
    return {bh ? BL : seg(h / 10), bh ? BL : seg(h % 10),
            bm ? BL : seg(m / 10), bm ? BL : seg(m % 10), seg(s / 10), seg(s % 10)};
  endfunction

  function automatic bit blk();
    return presc_m < CLK_HZ / 2;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled at the falling edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge Cp);
      presc_m = (presc_m == CLK_HZ - 1) ? 0 : presc_m + 1;
    end
  endtask

  // Advance exactly n seconds, stopping just after the n-th tick edge.
  task automatic wait_tick(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      while (presc_m != 0) step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; MODE = 1'b0; CMODE = 1'b0; Ch = 1'b0; SNZ = 1'b0; ALM = 2'b00; APM = 1'b0;
    step(2);
    reset = 1'b0;
    presc_m = 0;
  endtask

  task automatic pulse_mode();
    MODE = 1'b1; step(); MODE = 1'b0;
  endtask

  task automatic pulse_cmode(input bit clr);
    CMODE = 1'b1; step(); CMODE = 1'b0;
    if (clr) presc_m = 0;
  endtask

  task automatic pulse_ch(input int n);
    for (int i = 0; i < n; i++) begin
      Ch = 1'b1; step(); Ch = 1'b0; step();
    end
  endtask

  // Both alarms at 07:00, time 06:59:00 running, ALM = mask.
  task automatic setup_ring(input logic [1:0] mask);
    do_reset();
    pulse_mode(); pulse_cmode(0); pulse_cmode(0); pulse_ch(7); pulse_cmode(0);
    check("al0_prog", segs, disp(7, 0, 0, 0, 0));
    pulse_mode(); pulse_cmode(0); pulse_cmode(0); pulse_ch(7); pulse_cmode(0);
    pulse_mode();
    pulse_cmode(1); pulse_ch(59); pulse_cmode(0); pulse_ch(6); pulse_cmode(0);
    check("setup_0659", segs, disp(6, 59, 0, 0, 0));
    ALM = mask;
  endtask

  initial begin
    // Reset state, observed while reset is held.
    reset = 1'b1; MODE = 1'b0; CMODE = 1'b0; Ch = 1'b0; SNZ = 1'b0; ALM = 2'b00; APM = 1'b0;
    step();
    check("rst_disp", segs, disp(0, 0, 0, 0, 0));
    check("rst_pm", PM, 1'b0);
    check("rst_snd", SND, 1'b0);
    check("rst_idx", ALM_IDX, 1'b0);
    step();
    reset = 1'b0;
    presc_m = 0;

    // Minute edit: blink phases, 59 -> 00 without hour carry, time frozen.
    CMODE = 1'b1; step(); CMODE = 1'b0; presc_m = 0;
    check("blink_on", segs, disp(0, 0, 0, 0, 1));
    step();
    check("blink_off", segs, disp(0, 0, 0, 0, 0));
    pulse_ch(59);
    check("min_59", segs, disp(0, 59, 0, 0, blk()));
    pulse_ch(1);
    check("min_wrap", segs, disp(0, 0, 0, 0, blk()));
    step(3);
    check("frozen", segs, disp(0, 0, 0, 0, blk()));
    pulse_ch(59);
    pulse_cmode(0);
    check("hour_blink_a", segs, disp(0, 59, 0, blk(), 0));
    step();
    check("hour_blink_b", segs, disp(0, 59, 0, blk(), 0));
    pulse_ch(23);
    pulse_cmode(0);
    check("set_2359", segs, disp(23, 59, 0, 0, 0));
    check("pm_23", PM, 1'b1);
    wait_tick(59);
    check("t_235959", segs, disp(23, 59, 59, 0, 0));
    wait_tick(1);
    check("day_wrap", segs, disp(0, 0, 0, 0, 0));
    check("pm_wrap", PM, 1'b0);
    APM = 1'b1; #1;
    check("apm_midnight", segs, disp(12, 0, 0, 0, 0));
    check("apm_midnight_pm", PM, 1'b0);
    APM = 1'b0;

    // 13:05 in both display modes.
    pulse_cmode(1); pulse_ch(5); pulse_cmode(0); pulse_ch(13); pulse_cmode(0);
    APM = 1'b1; #1;
    check("apm_1305", segs, disp(1, 5, 0, 0, 0));
    check("apm_1305_pm", PM, 1'b1);
    APM = 1'b0; #1;
    check("h24_1305", segs, disp(13, 5, 0, 0, 0));
    check("h24_1305_pm", PM, 1'b1);

    // MODE and CMODE together: target advances, field stays RUN (Ch ignored).
    wait_tick(3);
    MODE = 1'b1; CMODE = 1'b1; step(); MODE = 1'b0; CMODE = 1'b0;
    pulse_ch(1);
    check("mode_wins", segs, disp(0, 0, 0, 0, 0));
    pulse_cmode(0); pulse_mode(); pulse_ch(1);
    check("mode_runs", segs, disp(0, 0, 0, 0, 0));

    // Ring on both alarms: lowest index, then timeout after 3 seconds.
    setup_ring(2'b11);
    wait_tick(59);
    check("pre_ring", segs, disp(6, 59, 59, 0, 0));
    check("pre_ring_snd", SND, 1'b0);
    wait_tick(1);
    check("ring_snd", SND, 1'b1);
    check("ring_idx0", ALM_IDX, 1'b0);
    check("ring_disp", segs, disp(7, 0, 0, 0, 0));
    wait_tick(2);
    check("ring_hold", SND, 1'b1);
    wait_tick(1);
    check("ring_timeout", SND, 1'b0);

    // Snooze at 07:00:01, re-ring at 07:05:00.
    setup_ring(2'b11);
    wait_tick(61);
    SNZ = 1'b1; step(); SNZ = 1'b0;
    check("snz_off", SND, 1'b0);
    wait_tick(298);
    check("snz_wait", segs, disp(7, 4, 59, 0, 0));
    check("snz_wait_snd", SND, 1'b0);
    wait_tick(1);
    check("snz_rering", SND, 1'b1);
    check("snz_idx", ALM_IDX, 1'b0);

    // Disabling the ringing alarm silences it and nothing re-rings.
    setup_ring(2'b11);
    wait_tick(60);
    check("dis_ring", SND, 1'b1);
    ALM = 2'b10; step();
    check("dis_off", SND, 1'b0);
    wait_tick(10);
    check("dis_stay", SND, 1'b0);

    // Only alarm 1 enabled, then asynchronous reset mid-ring.
    setup_ring(2'b10);
    wait_tick(60);
    check("ring_idx1_snd", SND, 1'b1);
    check("ring_idx1", ALM_IDX, 1'b1);
    reset = 1'b1; #1;
    check("rst_ring_snd", SND, 1'b0);
    check("rst_ring_idx", ALM_IDX, 1'b0);
    check("rst_ring_disp", segs, disp(0, 0, 0, 0, 0));
    do_reset();

    // Reset mid-edit returns to TIME/RUN, so Ch afterwards is ignored.
    pulse_cmode(1); pulse_ch(3);
    reset = 1'b1; #1;
    check("rst_edit_disp", segs, disp(0, 0, 0, 0, 0));
    do_reset();
    pulse_ch(2);
    e = disp(0, 0, 0, 0, 0);
    check("rst_edit_run", segs[41:14], e[41:14]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
